riscv_dmem: RTL and testbench
=============================

RISCV_DMEM -- requirements
Module: riscv_dmem

Interface
REQ-001 Parameter: AWIDTH, default 12, byte-address width (memory depth 2^(AWIDTH-2) words).
REQ-002 Parameter: WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-003 Parameter: MEM_INIT, default "", hex file loaded at time zero when non-empty.
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rstn  input  1  asynchronous, active-low reset.
REQ-006 i_dmem_req  input  1  request valid.
REQ-007 o_dmem_ready  output  1  request may be accepted this cycle.
REQ-008 i_dmem_wr_en  input  1  1 = store, 0 = load.
REQ-009 i_dmem_addr  input  AWIDTH  byte address.
REQ-010 i_dmem_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 i_dmem_strb  input  4  unshifted byte strobe from control (0001 byte, 0011 half, 1111 word).
REQ-012 i_dmem_funct3  input  3  load/store width and signedness (FUNCT3_MEM_* encoding).
REQ-013 o_dmem_rvalid  output  1  one-cycle response pulse, loads and stores.
REQ-014 o_dmem_rdata  output  32  load data, extended and right-aligned.
REQ-015 o_dmem_err  output  1  misaligned access flag, qualified by o_dmem_rvalid.

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 o_dmem_ready high in IDLE and RESP, low in WAIT.
REQ-018 Accept on edge with i_dmem_req && o_dmem_ready: capture addr, wdata, strb, funct3, wr_en; counter loads WAIT_CYCLES.
REQ-019 After accept: WAIT_CYCLES != 0 -> WAIT; WAIT_CYCLES == 0 -> RESP.
REQ-020 In WAIT: counter decrements each cycle; transition to RESP on the edge where counter reaches 1.
REQ-021 Latency: o_dmem_rvalid high exactly WAIT_CYCLES+1 cycles after the accept edge, for one cycle only. No back-pressure.
REQ-022 In RESP: new request accepted -> next state per REQ-019 (back-to-back, one request per WAIT_CYCLES+1 cycles); otherwise IDLE.
REQ-023 Lane strobe = i_dmem_strb << addr[1:0]; write data replicated to lanes per width.
REQ-024 Store commits on the edge that enters RESP, only on selected lanes; other bytes unchanged.
REQ-025 Load reads the word at addr[AWIDTH-1:2] on the edge that enters RESP; o_dmem_rdata registered.
REQ-026 Load extension: BYTE sign-extends lane addr[1:0]; BYTEU zero-extends it; HALF sign-extends half addr[1]; HALFU zero-extends it; WORD passes through.
REQ-027 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0 -> o_dmem_err=1 with rvalid, no memory write, o_dmem_rdata=0.
REQ-028 Unsupported funct3 (011, 110, 111) is treated as WORD.
REQ-029 o_dmem_rdata = 0 on store responses; o_dmem_rdata and o_dmem_err hold their values between pulses.
REQ-030 Address bits above AWIDTH are not decoded; word index wraps within the depth.

Reset
REQ-031 Reset asserted: state IDLE, counter 0, o_dmem_rvalid 0, o_dmem_rdata 0, o_dmem_err 0, o_dmem_ready 1 (IDLE).
REQ-032 Memory array is not reset; contents are retained.
REQ-033 Reset during WAIT aborts the transaction: no write commit and no response.

Structure
REQ-034 FUNCT3_MEM_* and new DMEM_ST_IDLE/WAIT/RESP constants live in the shared riscv_configs include.
REQ-035 Combinational lane logic (strobe shift, store replication, load extraction/extension, misalign detect) is a sub-module named riscv_dmem_align.
REQ-036 Storage is a word array with per-byte write enables, inferable as block RAM.

Verification
REQ-037 WAIT_CYCLES=1: sw 0xDEADBEEF @0x10, then lw @0x10 -> store rvalid 2 cycles after accept; load rdata=0xDEADBEEF, err=0.
REQ-038 sb 0x80 @0x13, then lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lw @0x10 -> 0x80ADBEEF.
REQ-039 sh 0x8001 @0x12, then lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001; lw @0x10 -> 0x8001BEEF.
REQ-040 lw @0x11 and sh @0x13 -> err=1 with rvalid, rdata=0; lw @0x10 is unchanged afterwards.
REQ-041 WAIT_CYCLES=0, req held high for 4 back-to-back stores -> ready never drops; rvalid high 4 consecutive cycles; all 4 words readable.
REQ-042 WAIT_CYCLES=3: reset pulse 2 cycles after a store accept -> no rvalid; a subsequent load returns the old word.

Source files
------------

// File: rtl/riscv_dmem_pkg.sv
// Shared constants for the data memory: load/store funct3 encodings,
// controller state encoding and a width decode helper.
package riscv_dmem_pkg;

  localparam logic [2:0] FUNCT3_MEM_B  = 3'b000;
  localparam logic [2:0] FUNCT3_MEM_H  = 3'b001;
  localparam logic [2:0] FUNCT3_MEM_W  = 3'b010;
  localparam logic [2:0] FUNCT3_MEM_BU = 3'b100;
  localparam logic [2:0] FUNCT3_MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_WAIT = 2'd1,
    DMEM_ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    MW_BYTE = 2'd0,
    MW_HALF = 2'd1,
    MW_WORD = 2'd2
  } mem_width_e;

  // Access width from funct3; the unused encodings (011, 110, 111) act as word.
  function automatic mem_width_e mem_width(input logic [2:0] f3);
    case (f3)
      FUNCT3_MEM_B, FUNCT3_MEM_BU: return MW_BYTE;
      FUNCT3_MEM_H, FUNCT3_MEM_HU: return MW_HALF;
      FUNCT3_MEM_W:                return MW_WORD;
      default:                     return MW_WORD;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_align.sv
// Byte-lane steering for the data memory: strobe shift, store data
// replication, load extraction/extension and misalignment detection.
module riscv_dmem_align
  import riscv_dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [3:0]  strb,
  input  logic [2:0]  funct3,
  input  logic [31:0] rword,
  output logic [3:0]  lane_strb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign bsel = rword[{addr_lo, 3'b000} +: 8];
  assign hsel = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Width-dependent lane steering; funct3[2] selects zero extension.
  always_comb begin
    lane_strb = strb << addr_lo;
    wdata_rep = wdata;
    rdata     = rword;
    misalign  = 1'b0;
    case (mem_width(funct3))
      MW_BYTE: begin
        wdata_rep = {4{wdata[7:0]}};
        rdata     = funct3[2] ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      end
      MW_HALF: begin
        wdata_rep = {2{wdata[15:0]}};
        rdata     = funct3[2] ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
        misalign  = addr_lo[0];
      end
      default: misalign = |addr_lo;
    endcase
    if (misalign) rdata = '0;
  end

endmodule

// File: rtl/riscv_dmem.sv
module riscv_dmem
  import riscv_dmem_pkg::*;
#(
  parameter int    AWIDTH      = 12,
  parameter int    WAIT_CYCLES = 1,
  parameter string MEM_INIT    = ""
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_dmem_req,
  output logic              o_dmem_ready,
  input  logic              i_dmem_wr_en,
  input  logic [AWIDTH-1:0] i_dmem_addr,
  input  logic [31:0]       i_dmem_wdata,
  input  logic [3:0]        i_dmem_strb,
  input  logic [2:0]        i_dmem_funct3,
  output logic              o_dmem_rvalid,
  output logic [31:0]       o_dmem_rdata,
  output logic              o_dmem_err
);

  localparam int         DEPTH     = 2 ** (AWIDTH - 2);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WC        = 4'(WAIT_CYCLES);

  logic [31:0] mem [DEPTH];

  dmem_state_e       state;
  logic [3:0]        cnt;
  logic [AWIDTH-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [2:0]        funct3_q;
  logic              wr_q;

  logic              accept, from_wait, do_resp;
  logic [AWIDTH-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [3:0]        op_strb;
  logic [2:0]        op_funct3;
  logic              op_wr;
  logic [AWIDTH-3:0] idx;
  logic [3:0]        lane_strb;
  logic [31:0]       wdata_rep, ext_rdata;
  logic              misalign;

  assign o_dmem_ready = (state != DMEM_ST_WAIT);
  assign accept       = i_dmem_req && o_dmem_ready;
  assign from_wait    = (state == DMEM_ST_WAIT);

  assign op_addr   = from_wait ? addr_q   : i_dmem_addr;
  assign op_wdata  = from_wait ? wdata_q  : i_dmem_wdata;
  assign op_strb   = from_wait ? strb_q   : i_dmem_strb;
  assign op_funct3 = from_wait ? funct3_q : i_dmem_funct3;
  assign op_wr     = from_wait ? wr_q     : i_dmem_wr_en;
  assign do_resp   = i_rstn && (from_wait ? (cnt == 4'd1) : (accept && ZERO_WAIT));
  assign idx       = op_addr[AWIDTH-1:2];

  riscv_dmem_align u_align (
    .addr_lo   (op_addr[1:0]),
    .wdata     (op_wdata),
    .strb      (op_strb),
    .funct3    (op_funct3),
    .rword     (mem[idx]),
    .lane_strb (lane_strb),
    .wdata_rep (wdata_rep),
    .rdata     (ext_rdata),
    .misalign  (misalign)
  );

  always_ff @(posedge i_clk) begin
    if (do_resp && op_wr && !misalign)
      for (int i = 0; i < 4; i++)
        if (lane_strb[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= DMEM_ST_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      funct3_q      <= '0;
      wr_q          <= 1'b0;
      o_dmem_rvalid <= 1'b0;
      o_dmem_rdata  <= '0;
      o_dmem_err    <= 1'b0;
    end else begin
      o_dmem_rvalid <= 1'b0;
      case (state)
        DMEM_ST_IDLE, DMEM_ST_RESP: begin
          if (accept) begin
            addr_q   <= i_dmem_addr;
            wdata_q  <= i_dmem_wdata;
            strb_q   <= i_dmem_strb;
            funct3_q <= i_dmem_funct3;
            wr_q     <= i_dmem_wr_en;
            cnt      <= WC;
            state    <= ZERO_WAIT ? DMEM_ST_RESP : DMEM_ST_WAIT;
          end else begin
            state <= DMEM_ST_IDLE;
          end
        end
        DMEM_ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DMEM_ST_RESP;
        end
        default: state <= DMEM_ST_IDLE;
      endcase
      if (do_resp) begin
        o_dmem_rvalid <= 1'b1;
        o_dmem_err    <= misalign;
        o_dmem_rdata  <= (op_wr || misalign) ? 32'b0 : ext_rdata;
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem.sv
// Directed bench: three instances (0, 1 and 3 wait states) exercised in turn.
module tb_riscv_dmem;

  logic        clk = 1'b0;
  logic        rstn, rstn3;
  logic [2:0]  req_v;
  logic        wr;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [2:0]  f3;

  logic        rdy0, rv0, er0, rdy1, rv1, er1, rdy3, rv3, er3;
  logic [31:0] rd0, rd1, rd3;

  int sel;
  logic        cur_rdy, cur_rv, cur_er;
  logic [31:0] cur_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_dmem #(.AWIDTH(12), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_dmem_req(req_v[0]), .o_dmem_ready(rdy0),
    .i_dmem_wr_en(wr), .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_dmem_strb(strb),
    .i_dmem_funct3(f3), .o_dmem_rvalid(rv0), .o_dmem_rdata(rd0), .o_dmem_err(er0));

  riscv_dmem #(.AWIDTH(12), .WAIT_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_dmem_req(req_v[1]), .o_dmem_ready(rdy1),
    .i_dmem_wr_en(wr), .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_dmem_strb(strb),
    .i_dmem_funct3(f3), .o_dmem_rvalid(rv1), .o_dmem_rdata(rd1), .o_dmem_err(er1));

  riscv_dmem #(.AWIDTH(12), .WAIT_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn3), .i_dmem_req(req_v[2]), .o_dmem_ready(rdy3),
    .i_dmem_wr_en(wr), .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_dmem_strb(strb),
    .i_dmem_funct3(f3), .o_dmem_rvalid(rv3), .o_dmem_rdata(rd3), .o_dmem_err(er3));

  always_comb begin
    cur_rdy = rdy1; cur_rv = rv1; cur_er = er1; cur_rd = rd1;
    case (sel)
      0: begin cur_rdy = rdy0; cur_rv = rv0; cur_er = er0; cur_rd = rd0; end
      2: begin cur_rdy = rdy3; cur_rv = rv3; cur_er = er3; cur_rd = rd3; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the selected instance; waits (bounded) for the response.
  task automatic txn(input string tag, input logic w, input logic [11:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic [2:0] f,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
    int lat;
    @(negedge clk);
    wr = w; addr = a; wdata = d; strb = s; f3 = f;
    req_v[sel] = 1'b1;
    @(posedge clk); #1;
    req_v = '0;
    lat = 1;
    while (!cur_rv && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/lat"}, lat, exp_lat);
    chk({tag, "/rdata"}, cur_rd, exp_rd);
    chk({tag, "/err"}, {31'b0, cur_er}, {31'b0, exp_er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    req_v = '0; wr = 0; addr = '0; wdata = '0; strb = '0; f3 = '0;
    rstn = 1'b0; rstn3 = 1'b0; sel = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/rvalid", {31'b0, rv1}, 32'd0);
    chk("rst/rdata",  rd1, 32'd0);
    chk("rst/err",    {31'b0, er1}, 32'd0);
    chk("rst/ready",  {31'b0, rdy1}, 32'd1);
    @(negedge clk);
    rstn = 1'b1; rstn3 = 1'b1;

    // One wait state: latency 2 counting the accept cycle.
    sel = 1;
    txn("sw10",   1, 12'h010, 32'hDEADBEEF, 4'b1111, 3'b010, 2, 32'h0, 1'b0);
    txn("lw10",   0, 12'h010, 32'h0,        4'b1111, 3'b010, 2, 32'hDEADBEEF, 1'b0);
    @(posedge clk); #1;
    chk("lw10/rv_drop", {31'b0, rv1}, 32'd0);
    chk("lw10/hold",    rd1, 32'hDEADBEEF);
    txn("sb13",   1, 12'h013, 32'hAAAAAA80, 4'b0001, 3'b000, 2, 32'h0, 1'b0);
    txn("lb13",   0, 12'h013, 32'h0, 4'b0001, 3'b000, 2, 32'hFFFFFF80, 1'b0);
    txn("lbu13",  0, 12'h013, 32'h0, 4'b0001, 3'b100, 2, 32'h00000080, 1'b0);
    txn("lw10b",  0, 12'h010, 32'h0, 4'b1111, 3'b010, 2, 32'h80ADBEEF, 1'b0);
    txn("sh12",   1, 12'h012, 32'h55558001, 4'b0011, 3'b001, 2, 32'h0, 1'b0);
    txn("lh12",   0, 12'h012, 32'h0, 4'b0011, 3'b001, 2, 32'hFFFF8001, 1'b0);
    txn("lhu12",  0, 12'h012, 32'h0, 4'b0011, 3'b101, 2, 32'h00008001, 1'b0);
    txn("lw10c",  0, 12'h010, 32'h0, 4'b1111, 3'b010, 2, 32'h8001BEEF, 1'b0);
    txn("lh10",   0, 12'h010, 32'h0, 4'b0011, 3'b001, 2, 32'hFFFFBEEF, 1'b0);
    txn("f3_011", 0, 12'h010, 32'h0, 4'b1111, 3'b011, 2, 32'h8001BEEF, 1'b0);
    txn("lw11",   0, 12'h011, 32'h0, 4'b1111, 3'b010, 2, 32'h0, 1'b1);
    txn("sh13",   1, 12'h013, 32'h0000FFFF, 4'b0011, 3'b001, 2, 32'h0, 1'b1);
    txn("lw10d",  0, 12'h010, 32'h0, 4'b1111, 3'b010, 2, 32'h8001BEEF, 1'b0);

    // Zero wait states, request held: four stores then four loads back to back.
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_v[0] = 1'b1; wr = 1'b1; addr = 12'(16'h40 + 4*i);
      wdata = 32'hC0DE0000 | i; strb = 4'b1111; f3 = 3'b010;
      chk("b2b_st/ready", {31'b0, rdy0}, 32'd1);
      @(posedge clk); #1;
      chk("b2b_st/rvalid", {31'b0, rv0}, 32'd1);
      chk("b2b_st/rdata", rd0, 32'd0);
    end
    @(negedge clk);
    req_v = '0;
    @(posedge clk); #1;
    chk("b2b_st/rv_drop", {31'b0, rv0}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_v[0] = 1'b1; wr = 1'b0; addr = 12'(16'h40 + 4*i);
      chk("b2b_ld/ready", {31'b0, rdy0}, 32'd1);
      @(posedge clk); #1;
      chk("b2b_ld/rvalid", {31'b0, rv0}, 32'd1);
      chk("b2b_ld/rdata", rd0, 32'hC0DE0000 | i);
    end
    @(negedge clk);
    req_v = '0;

    // Three wait states: reset during WAIT aborts the store.
    sel = 2;
    txn("sw20", 1, 12'h020, 32'h11111111, 4'b1111, 3'b010, 4, 32'h0, 1'b0);
    @(negedge clk);
    wr = 1'b1; addr = 12'h020; wdata = 32'h22222222; strb = 4'b1111; f3 = 3'b010;
    req_v[2] = 1'b1;
    @(posedge clk); #1;
    req_v = '0;
    chk("abort/ready_wait", {31'b0, rdy3}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn3 = 1'b0;
    #1;
    chk("abort/rst_ready", {31'b0, rdy3}, 32'd1);
    chk("abort/rst_rvalid", {31'b0, rv3}, 32'd0);
    @(negedge clk);
    rstn3 = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rv3) seen++;
    end
    chk("abort/no_rvalid", seen, 0);
    txn("lw20", 0, 12'h020, 32'h0, 4'b1111, 3'b010, 4, 32'h11111111, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
